// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared helpers for the serial pattern detector.
//   - st_w(pat_w): state register width, enough for S0..S(pat_w).
//   - fail_next(pattern, pat_w, k, b): KMP fallback state from Sk on a
//     mismatching bit b. Evaluated at elaboration only.
//   Pattern convention: first received bit is pattern[pat_w-1].
package seq_detect_pkg;

  localparam int unsigned PAT_W_MAX = 16;

  function automatic int unsigned st_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Single-bit extraction by shift keeps the index expression width-neutral.
  function automatic logic bit_at(input logic [PAT_W_MAX:0] v,
                                  input int unsigned i);
    logic [PAT_W_MAX:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Longest proper suffix of (prefix_k, b) that is also a pattern prefix.
  // The string s holds prefix bits at s[0..k-1] (oldest first) and b at s[k].
  function automatic int unsigned fail_next(input logic [PAT_W_MAX-1:0] pattern,
                                            input int unsigned          pat_w,
                                            input int unsigned          k,
                                            input logic                 b);
    logic [PAT_W_MAX:0] s;
    logic [PAT_W_MAX:0] p;
    int unsigned        best;
    logic               ok;
    s    = '0;
    p    = {1'b0, pattern};
    best = 0;
    for (int unsigned i = 0; i < k; i++) begin
      if (bit_at(p, pat_w - 1 - i)) s = s | ((PAT_W_MAX+1)'(1) << i);
    end
    if (b) s = s | ((PAT_W_MAX+1)'(1) << k);
    for (int unsigned j = 1; j <= k; j++) begin
      ok = 1'b1;
      for (int unsigned t = 0; t < j; t++) begin
        if (bit_at(s, k + 1 - j + t) != bit_at(p, pat_w - 1 - t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm
//   Parametrised serial pattern detector. State Sk means the first k pattern
//   bits have been matched; mismatches fall back along a KMP table built at
//   elaboration. Mealy (MOORE=0) flags a match in the cycle of the last bit;
//   Moore (MOORE=1) adds match state SM=PAT_W and flags one cycle later.
//   Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
//   and the match_count port.
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset to S0
//   x              in   serial data bit
//   x_valid        in   x consumed only when high
//   clear          in   synchronous return to S0, beats x_valid
//   y              out  match indication
//   current_state  out  state register
//   next_state     out  combinational next state
//   match_count    out  saturating match count (SEQDET_COUNT_EN only)
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = 4'b1011,
  parameter int unsigned         MOORE   = 0,
  parameter int unsigned         OVERLAP = 1,
  parameter int unsigned         CNT_W   = 8,
  localparam int unsigned        STW     = st_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clear,
  output logic             y,
  output logic [STW-1:0]   current_state,
  output logic [STW-1:0]   next_state
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  typedef enum logic [STW-1:0] {
    S0 = '0,
    SM = STW'(PAT_W)
  } state_e;

  localparam int unsigned    TBL_N    = 2 ** STW;
  localparam logic [STW-1:0] FAIL_END =
    STW'(fail_next(PAT_W_MAX'(PATTERN), PAT_W, PAT_W - 1, PATTERN[0]));
  // State from which the bit after a completion is interpreted.
  localparam logic [STW-1:0] BASE     = (OVERLAP != 0) ? FAIL_END : '0;
  localparam logic [STW-1:0] LAST     = STW'(PAT_W - 1);
  localparam logic [STW-1:0] TOP      = (MOORE != 0) ? STW'(PAT_W) : LAST;

  if (PAT_W < 2 || PAT_W > PAT_W_MAX || CNT_W < 1) begin : g_bad_cfg
    $error("seq_detect_fsm: PAT_W must be 2..16 and CNT_W >= 1");
  end

  state_e           r_state;
  logic [STW-1:0]   w_next;
  logic [STW-1:0]   w_eff;
  logic             w_done;
  logic [TBL_N-1:0] w_pbit;
  logic [STW-1:0]   w_fb0 [TBL_N];
  logic [STW-1:0]   w_fb1 [TBL_N];

  // Tables padded to a power of two so a full-width state indexes them.
  for (genvar gk = 0; gk < TBL_N; gk++) begin : g_tbl
    if (gk < PAT_W) begin : g_used
      assign w_pbit[gk] = PATTERN[PAT_W-1-gk];
      assign w_fb0[gk]  = STW'(fail_next(PAT_W_MAX'(PATTERN), PAT_W, gk, 1'b0));
      assign w_fb1[gk]  = STW'(fail_next(PAT_W_MAX'(PATTERN), PAT_W, gk, 1'b1));
    end else begin : g_pad
      assign w_pbit[gk] = 1'b0;
      assign w_fb0[gk]  = '0;
      assign w_fb1[gk]  = '0;
    end
  end

  // Next-state logic. SM is folded onto BASE so the match state needs no
  // table row of its own.
  always_comb begin
    w_eff  = r_state;
    w_next = r_state;
    w_done = 1'b0;
    if (MOORE != 0 && r_state == SM) w_eff = BASE;
    if (r_state > TOP) begin
      w_next = S0;
    end else if (clear) begin
      w_next = S0;
    end else if (x_valid) begin
      if (x == w_pbit[w_eff]) begin
        if (w_eff == LAST) begin
          w_done = 1'b1;
          w_next = (MOORE != 0) ? SM : BASE;
        end else begin
          w_next = w_eff + 1'b1;
        end
      end else begin
        w_next = x ? w_fb1[w_eff] : w_fb0[w_eff];
      end
    end
  end

  // Output logic.
  always_comb begin
    y = 1'b0;
    if (MOORE != 0) y = (r_state == SM);
    else            y = w_done;
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S0;
      r_count <= '0;
    end else begin
      r_state <= state_e'(w_next);
      if (w_done && r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  assign match_count = r_count;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S0;
    else       r_state <= state_e'(w_next);
  end
`endif

  assign current_state = r_state;
  assign next_state    = w_next;

endmodule
